// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

   // Sequencing states of the hazard controller.
   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_STALL2 = 2'd1,
      S_MUL    = 2'd2
   } state_t;

   // Decode-stage comparator operand sources.
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;

   // Maps a forwarding hit onto the comparator source encoding.
   function automatic logic [1:0] fwd_sel(input logic hit);
      return hit ? FWD_MEM : FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_controller_mul_busy_counter.sv
// Down-counter tracking the remaining busy cycles of a multi-cycle multiply.
module mul_busy_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   logic [W-1:0] count_r;

   // Load takes priority over decrement; the count saturates at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {W{1'b0}};
      end else if (load) begin
         count_r <= load_val;
      end else if (dec && (count_r != {W{1'b0}})) begin
         count_r <= count_r - W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;
   assign zero  = (count_r == {W{1'b0}});

endmodule

// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for a 5-stage pipeline with branches
// resolved in Decode. Optional stall-cycle counter: HAZARD_STALL_COUNTER_EN.
module hazard_controller
   import hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int MUL_CYCLES = 4,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              id_is_branch,
   input  logic              id_branch_taken,
   input  logic              id_is_jump,
   input  logic              id_is_mul,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_reg_write,
   input  logic              mem_mem_read,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic [1:0]        fwda_id,
   output logic [1:0]        fwdb_id,
   output logic [CNT_W-1:0]  stall_cycles
);

   localparam int MCW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

   state_t           state_r, state_nxt_s;
   logic             mul_mask_r;
   logic             mul_done_s;
   logic             stall_s, flush_s;
   logic             cnt_load_s, cnt_dec_s, cnt_zero_s;
   logic [MCW-1:0]   cnt_count_s;
   logic             ctl_s;
   logic             match_ex_s, match_mem_s;
   logic             load_use_s, br_ex_s, br_mem_s;
   logic             fwda_hit_s, fwdb_hit_s;

   // Register 0 is hard-wired, so it never creates a dependency.
   assign match_ex_s  = (ex_rd != {REG_AW{1'b0}}) &&
                        (((ex_rd == id_rs) && id_uses_rs) || ((ex_rd == id_rt) && id_uses_rt));
   assign match_mem_s = (mem_rd != {REG_AW{1'b0}}) &&
                        (((mem_rd == id_rs) && id_uses_rs) || ((mem_rd == id_rt) && id_uses_rt));

   assign ctl_s      = id_is_branch || id_is_jump;
   assign load_use_s = ex_mem_read && ex_reg_write && match_ex_s;
   assign br_ex_s    = ctl_s && ex_reg_write && !ex_mem_read && match_ex_s;
   assign br_mem_s   = ctl_s && mem_mem_read && match_mem_s;

   // Only ALU results in MEM feed the comparator; loads there are stalled on.
   assign fwda_hit_s = mem_reg_write && !mem_mem_read &&
                       (mem_rd != {REG_AW{1'b0}}) && (mem_rd == id_rs);
   assign fwdb_hit_s = mem_reg_write && !mem_mem_read &&
                       (mem_rd != {REG_AW{1'b0}}) && (mem_rd == id_rt);

   mul_busy_counter #(.W(MCW)) u_mul_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load_s),
      .load_val (MCW'(MUL_CYCLES - 2)),
      .dec      (cnt_dec_s),
      .count    (cnt_count_s),
      .zero     (cnt_zero_s)
   );

   // Next-state and stall/flush decision; hazards checked in priority order.
   always_comb begin
      state_nxt_s = state_r;
      stall_s     = 1'b0;
      flush_s     = 1'b0;
      cnt_load_s  = 1'b0;
      cnt_dec_s   = 1'b0;
      mul_done_s  = 1'b0;
      case (state_r)
         S_RUN: begin
            if (load_use_s) begin
               stall_s = 1'b1;
               // A branch/jr on a load needs a second bubble before resolving.
               if (ctl_s) begin
                  state_nxt_s = S_STALL2;
               end else begin
                  state_nxt_s = S_RUN;
               end
            end else if (br_ex_s || br_mem_s) begin
               stall_s = 1'b1;
            end else if (id_is_mul && !mul_mask_r) begin
               stall_s    = 1'b1;
               cnt_load_s = 1'b1;
               // With a two-cycle multiply this single stall is the whole wait.
               if (MUL_CYCLES > 2) begin
                  state_nxt_s = S_MUL;
               end else begin
                  state_nxt_s = S_RUN;
                  mul_done_s  = 1'b1;
               end
            end else begin
               flush_s = (id_is_branch && id_branch_taken) || id_is_jump;
            end
         end
         S_STALL2: begin
            stall_s     = 1'b1;
            state_nxt_s = S_RUN;
         end
         S_MUL: begin
            stall_s   = 1'b1;
            cnt_dec_s = 1'b1;
            if (cnt_zero_s || (cnt_count_s == MCW'(1))) begin
               state_nxt_s = S_RUN;
               mul_done_s  = 1'b1;
            end else begin
               state_nxt_s = S_MUL;
            end
         end
         default: begin
            stall_s     = 1'b1;
            state_nxt_s = S_RUN;
         end
      endcase
   end

   // State register; the mask lets a finished multiply leave Decode once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= S_RUN;
         mul_mask_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         mul_mask_r <= mul_done_s;
      end
   end

   // Reset holds the front end frozen with a bubble and no forwarding.
   always_comb begin
      if (!rst_n) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         ifid_flush  = 1'b0;
         fwda_id     = FWD_RF;
         fwdb_id     = FWD_RF;
      end else begin
         pc_write    = !stall_s;
         ifid_write  = !stall_s;
         idex_bubble = stall_s;
         ifid_flush  = flush_s && !stall_s;
         fwda_id     = fwd_sel(fwda_hit_s);
         fwdb_id     = fwd_sel(fwdb_hit_s);
      end
   end

`ifdef HAZARD_STALL_COUNTER_EN
   logic [CNT_W-1:0] stall_cnt_r;

   // Counts stall cycles only; wraps naturally at the counter width.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (stall_s) begin
         stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign stall_cycles = stall_cnt_r;
`else
   assign stall_cycles = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (MUL_CYCLES = 4).
module tb_hazard_controller;

   localparam int CNT_W = 32;
   // Expected output vector: {pc_write, ifid_write, ifid_flush, idex_bubble, fwda, fwdb}
   localparam logic [7:0] E_RUN   = 8'b1100_0000;
   localparam logic [7:0] E_STALL = 8'b0001_0000;
   localparam logic [7:0] E_FLUSH = 8'b1110_0000;
   localparam logic [7:0] FWDA    = 8'b0000_0100;
   localparam logic [7:0] FWDB    = 8'b0000_0001;
`ifdef HAZARD_STALL_COUNTER_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic clk, rst_n;
   logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
   logic id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken, id_is_jump, id_is_mul;
   logic ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read;
   logic pc_write, ifid_write, ifid_flush, idex_bubble;
   logic [1:0] fwda_id, fwdb_id;
   logic [CNT_W-1:0] stall_cycles;

   int checks   = 0;
   int failures = 0;

   hazard_controller #(.REG_AW(5), .MUL_CYCLES(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
      .id_is_jump(id_is_jump), .id_is_mul(id_is_mul),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .fwda_id(fwda_id), .fwdb_id(fwdb_id),
      .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clr();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
      id_is_branch = 1'b0; id_branch_taken = 1'b0; id_is_jump = 1'b0; id_is_mul = 1'b0;
      ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
      mem_rd = 5'd0; mem_reg_write = 1'b0; mem_mem_read = 1'b0;
   endtask

   // Samples mid-cycle, compares, then advances to just after the next edge.
   task automatic chk(input string tag, input logic [7:0] exp);
      logic [7:0] obs;
      #4;
      obs = {pc_write, ifid_write, ifid_flush, idex_bubble, fwda_id, fwdb_id};
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
      @(posedge clk); #1;
   endtask

   task automatic chk_cnt(input string tag, input int n);
      logic [CNT_W-1:0] exp;
      exp = CNT_ON ? CNT_W'(n) : {CNT_W{1'b0}};
      checks++;
      assert (stall_cycles === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, stall_cycles, exp);
      end
   endtask

   initial begin
      clr(); rst_n = 1'b0;
      @(posedge clk); #1;
      // Reset forces a frozen front end even with a forwarding candidate present.
      mem_rd = 5'd3; mem_reg_write = 1'b1; id_rs = 5'd3; id_uses_rs = 1'b1;
      chk("reset_out", E_STALL);
      chk_cnt("reset_cnt", 0);
      rst_n = 1'b1; clr();
      chk("idle_run", E_RUN);

      // lw $2 ; add $3,$2,$4
      id_rs = 5'd2; id_rt = 5'd4; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
      ex_rd = 5'd2; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
      chk("lu_stall", E_STALL);
      ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
      mem_rd = 5'd2; mem_reg_write = 1'b1; mem_mem_read = 1'b1;
      chk("lu_release", E_RUN);
      // Load target not actually read: no stall; then read via Rt: stall.
      clr(); id_rs = 5'd2; id_rt = 5'd3; id_uses_rt = 1'b1;
      ex_rd = 5'd2; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
      chk("lu_unused_rs", E_RUN);
      id_rt = 5'd2;
      chk("lu_rt", E_STALL);

      // lw $2 ; beq $2,$5 taken
      clr(); id_rs = 5'd2; id_rt = 5'd5; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
      id_is_branch = 1'b1; id_branch_taken = 1'b1;
      ex_rd = 5'd2; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
      chk("lb_stall1", E_STALL);
      ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
      mem_rd = 5'd2; mem_reg_write = 1'b1; mem_mem_read = 1'b1;
      chk("lb_stall2", E_STALL);
      mem_rd = 5'd0; mem_reg_write = 1'b0; mem_mem_read = 1'b0;
      chk("lb_flush", E_FLUSH);
      clr(); id_rs = 5'd6; id_uses_rs = 1'b1;
      chk("lb_after", E_RUN);

      // lw $7 ; jr $7 -- second stall comes from state alone (inputs hazard-free)
      clr(); id_rs = 5'd7; id_uses_rs = 1'b1; id_is_jump = 1'b1;
      ex_rd = 5'd7; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
      chk("lj_stall1", E_STALL);
      ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
      chk("lj_stall2", E_STALL);
      chk("lj_flush", E_FLUSH);
      chk_cnt("cnt_mid", 6);

      // add $2 ; beq $2,$0
      clr(); id_rs = 5'd2; id_rt = 5'd0; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
      id_is_branch = 1'b1; id_branch_taken = 1'b1;
      ex_rd = 5'd2; ex_reg_write = 1'b1;
      chk("ab_stall", E_STALL);
      ex_rd = 5'd0; ex_reg_write = 1'b0; mem_rd = 5'd2; mem_reg_write = 1'b1;
      chk("ab_fwd_flush", E_FLUSH | FWDA);
      id_branch_taken = 1'b0;
      chk("ab_fwd_nt", E_RUN | FWDA);
      clr(); id_rs = 5'd9; id_rt = 5'd9; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
      mem_rd = 5'd9; mem_reg_write = 1'b1;
      chk("fwd_both", E_RUN | FWDA | FWDB);
      mem_mem_read = 1'b1;
      chk("fwd_load_none", E_RUN);

      // Branch on a load sitting in MEM
      clr(); id_rs = 5'd3; id_uses_rs = 1'b1; id_is_branch = 1'b1;
      mem_rd = 5'd3; mem_reg_write = 1'b1; mem_mem_read = 1'b1;
      chk("bm_stall", E_STALL);
      mem_rd = 5'd0; mem_reg_write = 1'b0; mem_mem_read = 1'b0;
      chk("bm_release", E_RUN);
      clr(); id_is_jump = 1'b1;
      chk("jmp_flush", E_FLUSH);

      // Two back-to-back multiplies
      clr(); id_is_mul = 1'b1;
      chk("mul1_a", E_STALL); chk("mul1_b", E_STALL); chk("mul1_c", E_STALL);
      chk("mul1_go", E_RUN);
      chk("mul2_a", E_STALL); chk("mul2_b", E_STALL); chk("mul2_c", E_STALL);
      chk("mul2_go", E_RUN);
      clr();
      chk_cnt("cnt_pre_reset", 14);

      // Reset in the second cycle of a multiply stall
      id_is_mul = 1'b1;
      chk("mr_a", E_STALL);
      rst_n = 1'b0;
      id_rs = 5'd4; id_uses_rs = 1'b1; id_is_branch = 1'b1; id_branch_taken = 1'b1;
      mem_rd = 5'd4; mem_reg_write = 1'b1;
      chk("mr_reset", E_STALL);
      chk_cnt("mr_cnt", 0);
      rst_n = 1'b1; clr();
      chk("mr_after", E_RUN);

      // Register 0 never hazards or forwards
      clr(); id_uses_rs = 1'b1; id_uses_rt = 1'b1;
      ex_reg_write = 1'b1; ex_mem_read = 1'b1;
      chk("r0_lu", E_RUN);
      ex_mem_read = 1'b0; ex_reg_write = 1'b0; mem_reg_write = 1'b1;
      chk("r0_fwd", E_RUN);
      mem_reg_write = 1'b0; ex_reg_write = 1'b1; id_is_branch = 1'b1;
      chk("r0_br", E_RUN);

      clr(); id_rt = 5'd8; id_uses_rt = 1'b1;
      ex_rd = 5'd8; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
      chk("final_lu", E_STALL);
      chk_cnt("cnt_final", 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard and sequencing controller for the 5-stage processor (Fetch, Decode, Execute, Memory, Writeback), with branches resolved in Decode.
- Detects load-use, branch-compare and multi-cycle-multiply hazards.
- Drives PC/IF-ID write enables, the ID-EX bubble and the IF-ID flush.
- Selects forwarding sources for the Decode-stage branch comparator.

Parameters:
- REG_AW, 5, register address width.
- MUL_CYCLES, 4, total execute cycles of a multi-cycle multiply (legal range 2..16).
- CNT_W, 32, width of the stall-cycle counter (optional feature).

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- ID_Rs  in  REG_AW  Decode source register A
- ID_Rt  in  REG_AW  Decode source register B
- ID_UsesRs  in  1  Decode instruction reads Rs
- ID_UsesRt  in  1  Decode instruction reads Rt
- ID_IsBranch  in  1  conditional branch (compare in Decode)
- ID_BranchTaken  in  1  comparator result; valid when ID_IsBranch
- ID_IsJump  in  1  unconditional jump/jr in Decode
- ID_IsMul  in  1  multi-cycle multiply in Decode
- EX_Rd  in  REG_AW  Execute destination register
- EX_RegWrite  in  1  Execute instruction writes a register
- EX_MemRead  in  1  Execute instruction is a load
- MEM_Rd  in  REG_AW  Memory destination register
- MEM_RegWrite  in  1  Memory instruction writes a register
- MEM_MemRead  in  1  Memory instruction is a load
- PC_Write  out  1  PC update enable
- IFID_Write  out  1  IF/ID register enable
- IFID_Flush  out  1  zero the IF/ID register (squash the fetched instruction)
- IDEX_Bubble  out  1  insert a NOP into ID/EX
- FwdA_ID  out  2  comparator A source: 00 = register file, 01 = MEM ALU result
- FwdB_ID  out  2  comparator B source (same encoding as FwdA_ID)
- Stall_Cycles  out  CNT_W  count of stall cycles

Behaviour:
- Definitions:
  - matchX(r) = (r != 0) & (r == ID_Rs & ID_UsesRs | r == ID_Rt & ID_UsesRt).
  - stall = PC_Write = 0, IFID_Write = 0, IDEX_Bubble = 1.
- States: RUN, STALL2, MUL. State and counter are registered. All outputs are combinational from state and inputs.
- While Rst_n is low:
  - state = RUN, mul counter = 0, Stall_Cycles = 0.
  - Outputs forced to PC_Write = 0, IFID_Write = 0, IDEX_Bubble = 1, IFID_Flush = 0, Fwd = 00.
  - Reset mid-stall or mid-MUL abandons the sequence immediately.
- RUN, hazard conditions, highest first:
  1. Load-use: EX_MemRead & EX_RegWrite & matchX(EX_Rd). Stall this cycle. If ID_IsBranch or ID_IsJump (jr) as well, go to STALL2; else stay in RUN.
  2. Branch on EX ALU result: (ID_IsBranch | ID_IsJump) & EX_RegWrite & !EX_MemRead & matchX(EX_Rd). Stall one cycle.
  3. Branch on MEM load: (ID_IsBranch | ID_IsJump) & MEM_MemRead & matchX(MEM_Rd). Stall one cycle.
  4. ID_IsMul: stall, load counter with MUL_CYCLES-2, go to MUL.
  5. Otherwise, no stall. If (ID_IsBranch & ID_BranchTaken) | ID_IsJump, assert IFID_Flush for 1 cycle.
- STALL2: stall exactly one more cycle, then go to RUN. The load is then in MEM, so re-evaluation in RUN hits rule 3 → total branch-after-load penalty = 2 cycles.
- MUL: stall every cycle. Counter decrements; at 0 go to RUN. Total stall = MUL_CYCLES-1 cycles. The instruction then proceeds with no re-stall: rule 4 is masked for one cycle after MUL exit.
- Flush is never asserted in a stall cycle. A stall takes priority; the branch is resolved after the stall clears.
- Forwarding: FwdA_ID = 01 iff MEM_RegWrite & !MEM_MemRead & MEM_Rd != 0 & MEM_Rd == ID_Rs; else 00. FwdB_ID is the same using ID_Rt. The register file is write-first, so no WB path is needed.
- Register 0 never causes a hazard or forward.

Optional Feature:
- Macro: HAZARD_STALL_COUNTER_EN.
- Defined: Stall_Cycles increments by 1 on every stall cycle (not flush cycles) while Rst_n is high. It wraps at 2^CNT_W.
- Undefined: no counter register; Stall_Cycles is tied to 0.

Decomposition:
- Shared package/header hazard_pkg:
  - State encodings S_RUN = 2'd0, S_STALL2 = 2'd1, S_MUL = 2'd2.
  - Forward encodings FWD_RF = 2'b00, FWD_MEM = 2'b01.
- One natural sub-module: mul_busy_counter (load, decrement, zero flag). Hazard compare logic stays inline.

Test Plan:
- lw $2 then add $3,$2,$4 → one cycle with PC_Write = 0, IDEX_Bubble = 1; FwdA_ID = 00; no flush.
- lw $2 then beq $2,$5 (taken) → 2 stall cycles (RUN → STALL2 → RUN), then IFID_Flush = 1 for exactly 1 cycle.
- add $2 then beq $2,$0 → 1 stall; next cycle FwdA_ID = 01, and flush if taken.
- mul with MUL_CYCLES = 4 → 3 consecutive stall cycles, then the pipeline advances; a following mul restalls 3 cycles.
- Reset asserted in cycle 2 of the MUL stall → outputs frozen, state RUN. After release, the first cycle with no hazard gives PC_Write = 1. Stall_Cycles = 0.
- Writes to $0 by a load followed by a use of $0 → no stall, no forward. With HAZARD_STALL_COUNTER_EN, Stall_Cycles equals the total stalls from all the scenarios above.
